mem_sched3: RTL and testbench

MEM_SCHED3 -- requirements
Module: mem_sched3

---
 rtl/harvos_pkg.sv | 39 +++
 rtl/harvos_sched_pick.sv | 22 ++
 rtl/mem_sched3.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_sched3.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvos_pkg.sv
// Shared types and constants for the mem_sched3 memory scheduler:
// FSM state enum, requester indices, command struct and the fixed-priority helper.
package harvos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Requester indices into the packed request/grant vectors.
  localparam int SCHED_D    = 0;
  localparam int SCHED_I    = 1;
  localparam int SCHED_X    = 2;
  localparam int SCHED_NREQ = 3;

  localparam int SCHED_TIMEOUT_DEFAULT   = 255;
  localparam int SCHED_AGE_LIMIT_DEFAULT = 15;

  // One requester's command as presented to the RAM.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sched_cmd_t;

  // Fixed priority d > i > x, returns a one-hot (or all-zero) grant.
  function automatic logic [SCHED_NREQ-1:0] sched_prio_pick(input logic [SCHED_NREQ-1:0] req);
    logic [SCHED_NREQ-1:0] g;
    g = '0;
    if (req[SCHED_D])      g[SCHED_D] = 1'b1;
    else if (req[SCHED_I]) g[SCHED_I] = 1'b1;
    else if (req[SCHED_X]) g[SCHED_X] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/harvos_sched_pick.sv
// Combinational grant selection: aged requesters first, then plain d > i > x.
module harvos_sched_pick
  import harvos_pkg::*;
(
  input  logic [SCHED_NREQ-1:0] i_req,
  input  logic [SCHED_NREQ-1:0] i_aged,
  output logic [SCHED_NREQ-1:0] o_grant
);

  logic [SCHED_NREQ-1:0] w_aged_req;

  assign w_aged_req = i_req & i_aged;

  // Any aged requester pre-empts the base order; ties among aged use the base order.
  always_comb begin
    o_grant = sched_prio_pick(i_req);
    if (|w_aged_req) begin
      o_grant = sched_prio_pick(w_aged_req);
    end
  end

endmodule

// File: rtl/mem_sched3.sv
// mem_sched3: three-requester (D$, I$, DMA) single-outstanding RAM scheduler.
// IDLE picks a grantee, ISSUE pulses m_req, WAIT collects the RAM answer or
// times out with a synthesized fault, RESP pulses the grantee's p_rvalid.
// Optional aging of starving requesters is enabled by HARVOS_SCHED_AGING_EN.
module mem_sched3
  import harvos_pkg::*;
#(
  parameter int TIMEOUT_CYC = SCHED_TIMEOUT_DEFAULT,
  parameter int AGE_LIMIT   = SCHED_AGE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  // D$ requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_fault,
  // I$ requester
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_fault,
  // DMA requester
  input  logic        x_req,
  input  logic        x_we,
  input  logic [3:0]  x_be,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  output logic [31:0] x_rdata,
  output logic        x_rvalid,
  output logic        x_fault,
  // RAM side
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_fault
);

  localparam logic [8:0] TO_CNT   = 9'(TIMEOUT_CYC);
  localparam logic [4:0] AGE_LIM5 = 5'(AGE_LIMIT);

  genvar gi;

  sched_state_e          r_state;
  sched_state_e          w_state_next;
  logic [SCHED_NREQ-1:0] w_req;
  logic [SCHED_NREQ-1:0] w_aged;
  logic [SCHED_NREQ-1:0] w_grant;
  logic [SCHED_NREQ-1:0] r_grant;
  sched_cmd_t            w_cmd [SCHED_NREQ];
  sched_cmd_t            w_sel_cmd;
  logic [8:0]            r_cnt;
  logic [8:0]            w_cnt_inc;
  logic                  w_start;
  logic                  w_finish;

  logic                  r_m_req;
  logic                  r_m_we;
  logic [3:0]            r_m_be;
  logic [31:0]           r_m_addr;
  logic [31:0]           r_m_wdata;

  logic [SCHED_NREQ-1:0] w_rvalid;
  logic [SCHED_NREQ-1:0] w_fault;
  logic [31:0]           w_rdata [SCHED_NREQ];

  assign w_req = {x_req, i_req, d_req};

  assign w_cmd[SCHED_D] = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
  assign w_cmd[SCHED_I] = '{we: i_we, be: i_be, addr: i_addr, wdata: i_wdata};
  assign w_cmd[SCHED_X] = '{we: x_we, be: x_be, addr: x_addr, wdata: x_wdata};

  assign w_cnt_inc = r_cnt + 9'd1;
  assign w_start   = (r_state == ST_IDLE) && (|w_req);
  assign w_finish  = (r_state == ST_WAIT) && (w_state_next == ST_RESP);

  harvos_sched_pick u_pick (
    .i_req   (w_req),
    .i_aged  (w_aged),
    .o_grant (w_grant)
  );

`ifdef HARVOS_SCHED_AGING_EN
  for (gi = 0; gi < SCHED_NREQ; gi++) begin : g_age
    logic [3:0] r_age;

    // Saturating count of IDLE decisions this requester asked for and lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_age <= '0;
      end else if (w_start) begin
        if (w_grant[gi]) begin
          r_age <= '0;
        end else if (w_req[gi] && (r_age != 4'hF)) begin
          r_age <= r_age + 4'd1;
        end
      end
    end

    assign w_aged[gi] = ({1'b0, r_age} >= AGE_LIM5);
  end
`else
  // No aging state: every requester carries the same aged flag, so the
  // picker always resolves on the fixed d > i > x order.
  assign w_aged = {SCHED_NREQ{AGE_LIM5 == 5'd0}};
`endif

  // Mux the granted requester's command.
  always_comb begin
    w_sel_cmd = '0;
    for (int p = 0; p < SCHED_NREQ; p++) begin
      if (w_grant[p]) begin
        w_sel_cmd = w_cmd[p];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a real RAM answer wins over a same-cycle timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_rvalid || (w_cnt_inc == TO_CNT)) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // WAIT timer: zero when WAIT is entered, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // RAM command registers: loaded on grant, m_req dropped after ISSUE,
  // command held through WAIT and cleared once the response is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else if (w_start) begin
      r_grant   <= w_grant;
      r_m_req   <= 1'b1;
      r_m_we    <= w_sel_cmd.we;
      r_m_be    <= w_sel_cmd.be;
      r_m_addr  <= w_sel_cmd.addr;
      r_m_wdata <= w_sel_cmd.wdata;
    end else if (r_state == ST_ISSUE) begin
      r_m_req <= 1'b0;
    end else if (w_finish) begin
      r_m_we    <= 1'b0;
      r_m_be    <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end
  end

  for (gi = 0; gi < SCHED_NREQ; gi++) begin : g_resp
    logic        r_rvalid;
    logic        r_fault;
    logic [31:0] r_rdata;

    // Per-requester response: one-cycle rvalid/fault pulse, rdata held until the next own response.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rvalid <= 1'b0;
        r_fault  <= 1'b0;
        r_rdata  <= '0;
      end else if (w_finish && r_grant[gi]) begin
        r_rvalid <= 1'b1;
        r_fault  <= m_rvalid ? m_fault : 1'b1;
        r_rdata  <= m_rvalid ? m_rdata : 32'h0;
      end else begin
        r_rvalid <= 1'b0;
        r_fault  <= 1'b0;
      end
    end

    assign w_rvalid[gi] = r_rvalid;
    assign w_fault[gi]  = r_fault;
    assign w_rdata[gi]  = r_rdata;
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  assign d_rvalid = w_rvalid[SCHED_D];
  assign d_fault  = w_fault[SCHED_D];
  assign d_rdata  = w_rdata[SCHED_D];
  assign i_rvalid = w_rvalid[SCHED_I];
  assign i_fault  = w_fault[SCHED_I];
  assign i_rdata  = w_rdata[SCHED_I];
  assign x_rvalid = w_rvalid[SCHED_X];
  assign x_fault  = w_fault[SCHED_X];
  assign x_rdata  = w_rdata[SCHED_X];

endmodule

// File: tb/tb_mem_sched3.sv
// Directed self-checking bench for mem_sched3 (default timeout 255, age limit 15).
// The aging scenario is selected by HARVOS_SCHED_AGING_EN.
module tb_mem_sched3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_req = 0, d_we = 0; logic [3:0] d_be = 0; logic [31:0] d_addr = 0, d_wdata = 0;
  logic        i_req = 0, i_we = 0; logic [3:0] i_be = 0; logic [31:0] i_addr = 0, i_wdata = 0;
  logic        x_req = 0, x_we = 0; logic [3:0] x_be = 0; logic [31:0] x_addr = 0, x_wdata = 0;
  logic [31:0] d_rdata, i_rdata, x_rdata;
  logic        d_rvalid, i_rvalid, x_rvalid, d_fault, i_fault, x_fault;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_fault;

  // RAM model controls
  logic        ram_auto = 0;       // answer one cycle after m_req
  logic        ram_use_addr = 0;   // rdata = {16'hC0DE, addr[15:0]} instead of ram_data
  logic [31:0] ram_data = 0;
  logic        ram_flt = 0;
  logic        man_v = 0, man_f = 0;
  logic [31:0] man_d = 0;
  logic        pend = 0;
  logic [31:0] pend_addr = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_sched3 dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_fault(d_fault),
    .i_req(i_req), .i_we(i_we), .i_be(i_be), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_fault(i_fault),
    .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_rdata(x_rdata), .x_rvalid(x_rvalid), .x_fault(x_fault),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_fault(m_fault)
  );

  // RAM model, driven on the falling edge.
  always @(negedge clk) begin
    if (ram_auto) begin
      m_rvalid = pend;
      m_rdata  = pend ? (ram_use_addr ? {16'hC0DE, pend_addr[15:0]} : ram_data) : 32'h0;
      m_fault  = pend & ram_flt;
      pend      = m_req;
      pend_addr = m_addr;
    end else begin
      m_rvalid = man_v;
      m_rdata  = man_d;
      m_fault  = man_f;
      pend     = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== 70'h0) begin n_err++;
      $display("FAIL reset_m: got %h expected 0", {m_req, m_we, m_be, m_addr, m_wdata}); end
    n_cmp++; if ({d_rvalid, i_rvalid, x_rvalid, d_fault, i_fault, x_fault} !== 6'h0) begin n_err++;
      $display("FAIL reset_p: got %b expected 000000", {d_rvalid, i_rvalid, x_rvalid, d_fault, i_fault, x_fault}); end
    n_cmp++; if ({d_rdata, i_rdata, x_rdata} !== 96'h0) begin n_err++;
      $display("FAIL reset_rdata: got %h expected 0", {d_rdata, i_rdata, x_rdata}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (m_req !== 1'b0) begin n_err++;
      $display("FAIL idle_no_req: m_req got %b expected 0", m_req); end
    $display("txn reset released");
  endtask

  task automatic test_read();
    ram_auto = 1; ram_use_addr = 0; ram_data = 32'hDEADBEEF; ram_flt = 0;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4000; d_wdata = 0;
    tick();
    n_cmp++; if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h4000}) begin n_err++;
      $display("FAIL read_issue: got req=%b we=%b addr=%h expected 1 0 00004000", m_req, m_we, m_addr); end
    tick();
    n_cmp++; if ({m_req, m_addr} !== {1'b0, 32'h4000}) begin n_err++;
      $display("FAIL read_wait: got req=%b addr=%h expected 0 00004000", m_req, m_addr); end
    tick();
    n_cmp++; if ({d_rvalid, d_fault, d_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin n_err++;
      $display("FAIL read_resp: got v=%b f=%b d=%h expected 1 0 deadbeef", d_rvalid, d_fault, d_rdata); end
    n_cmp++; if ({i_rvalid, x_rvalid} !== 2'b00) begin n_err++;
      $display("FAIL read_other: got %b expected 00", {i_rvalid, x_rvalid}); end
    d_req = 0;
    tick();
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_err++;
      $display("FAIL read_after: got v=%b d=%h expected 0 deadbeef", d_rvalid, d_rdata); end
    $display("txn d read addr=00004000 rdata=%h", d_rdata);
  endtask

  task automatic test_three();
    int order [3];
    int at [3];
    int n = 0;
    int nresp = 0;
    ram_auto = 1; ram_use_addr = 1; ram_flt = 0;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    i_req = 1; i_we = 0; i_addr = 32'h200;
    x_req = 1; x_we = 0; x_addr = 32'h300;
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      tick();
      if (m_req) begin
        if (n < 3) begin order[n] = int'(m_addr[11:8]); at[n] = c; end
        n++;
      end
      if (d_rvalid) begin d_req = 0; nresp++; end
      if (i_rvalid) begin i_req = 0; nresp++; end
      if (x_rvalid) begin x_req = 0; nresp++; end
    end
    d_req = 0; i_req = 0; x_req = 0;
    n_cmp++; if (n !== 3) begin n_err++;
      $display("FAIL three_count: m_req pulses got %0d expected 3", n); end
    if (n >= 3) begin
      n_cmp++; if ({order[0], order[1], order[2]} !== {32'd1, 32'd2, 32'd3}) begin n_err++;
        $display("FAIL three_order: got %0d %0d %0d expected 1 2 3", order[0], order[1], order[2]); end
      n_cmp++; if ({at[1] - at[0], at[2] - at[1]} !== {32'd4, 32'd4}) begin n_err++;
        $display("FAIL three_gap: got %0d %0d expected 4 4", at[1] - at[0], at[2] - at[1]); end
    end
    tick();
    n_cmp++; if ({d_rdata, i_rdata, x_rdata} !== {32'hC0DE0100, 32'hC0DE0200, 32'hC0DE0300}) begin n_err++;
      $display("FAIL three_data: got %h %h %h expected c0de0100 c0de0200 c0de0300", d_rdata, i_rdata, x_rdata); end
    $display("txn d,i,x reads order done rdata %h %h %h", d_rdata, i_rdata, x_rdata);
  endtask

  task automatic test_timeout();
    int cnt = 0;
    ram_auto = 0; man_v = 0;
    x_req = 1; x_we = 1; x_be = 4'h3; x_addr = 32'h8000; x_wdata = 32'h12345678;
    tick();
    n_cmp++; if ({m_req, m_we, m_be, m_wdata} !== {1'b1, 1'b1, 4'h3, 32'h12345678}) begin n_err++;
      $display("FAIL to_issue: got req=%b we=%b be=%h wd=%h expected 1 1 3 12345678", m_req, m_we, m_be, m_wdata); end
    while (cnt < 300) begin
      tick();
      cnt++;
      if (cnt == 200) begin
        n_cmp++; if ({m_we, m_be, m_addr} !== {1'b1, 4'h3, 32'h8000}) begin n_err++;
          $display("FAIL to_hold: got we=%b be=%h addr=%h expected 1 3 00008000", m_we, m_be, m_addr); end
      end
      if (x_rvalid) break;
    end
    n_cmp++; if (cnt !== 256) begin n_err++;
      $display("FAIL to_latency: x_rvalid after %0d edges expected 256", cnt); end
    n_cmp++; if ({x_rvalid, x_fault, x_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_err++;
      $display("FAIL to_resp: got v=%b f=%b d=%h expected 1 1 00000000", x_rvalid, x_fault, x_rdata); end
    x_req = 0;
    tick();
    n_cmp++; if ({x_rvalid, x_fault} !== 2'b00) begin n_err++;
      $display("FAIL to_pulse: got %b expected 00", {x_rvalid, x_fault}); end
    man_v = 1; man_d = 32'hFFFFFFFF; man_f = 1;
    tick(); tick();
    man_v = 0; man_d = 0; man_f = 0;
    tick();
    n_cmp++; if ({m_req, d_rvalid, i_rvalid, x_rvalid, x_rdata} !== {4'b0000, 32'h0}) begin n_err++;
      $display("FAIL late_ignored: got req=%b v=%b%b%b xd=%h expected 0 000 0", m_req, d_rvalid, i_rvalid, x_rvalid, x_rdata); end
    $display("txn x write timeout after %0d edges fault=1", cnt);
  endtask

  task automatic test_reset_mid();
    bit saw_i = 0;
    ram_auto = 0;
    i_req = 1; i_we = 1; i_be = 4'hF; i_addr = 32'h22220000; i_wdata = 32'hAAAA5555;
    tick(); tick(); tick();
    n_cmp++; if (m_addr !== 32'h22220000) begin n_err++;
      $display("FAIL rm_wait: m_addr got %h expected 22220000", m_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== 70'h0) begin n_err++;
      $display("FAIL rm_m_zero: got %h expected 0", {m_req, m_we, m_be, m_addr, m_wdata}); end
    n_cmp++; if ({d_rdata, i_rdata, x_rdata, d_rvalid, i_rvalid, x_rvalid} !== 99'h0) begin n_err++;
      $display("FAIL rm_p_zero: got %h expected 0", {d_rdata, i_rdata, x_rdata, d_rvalid, i_rvalid, x_rvalid}); end
    i_req = 0;
    d_req = 1; d_we = 0; d_addr = 32'h4444;
    ram_auto = 1; ram_use_addr = 1; ram_flt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if ({m_req, m_addr} !== {1'b1, 32'h4444}) begin n_err++;
      $display("FAIL rm_first_grant: got req=%b addr=%h expected 1 00004444", m_req, m_addr); end
    tick();
    if (i_rvalid) saw_i = 1;
    tick();
    if (i_rvalid) saw_i = 1;
    n_cmp++; if ({d_rvalid, d_fault, d_rdata} !== {1'b1, 1'b0, 32'hC0DE4444}) begin n_err++;
      $display("FAIL rm_d_resp: got v=%b f=%b d=%h expected 1 0 c0de4444", d_rvalid, d_fault, d_rdata); end
    d_req = 0;
    tick();
    if (i_rvalid) saw_i = 1;
    n_cmp++; if (saw_i !== 1'b0) begin n_err++;
      $display("FAIL rm_no_i_resp: i_rvalid seen got 1 expected 0"); end
    $display("txn reset mid-i-write discarded, d read rdata=%h", d_rdata);
  endtask

  task automatic test_fault();
    ram_auto = 1; ram_use_addr = 1; ram_flt = 1;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'h55;
    tick(); tick(); tick();
    n_cmp++; if ({d_rvalid, d_fault} !== 2'b11) begin n_err++;
      $display("FAIL flt_resp: got v=%b f=%b expected 1 1", d_rvalid, d_fault); end
    d_req = 0;
    tick();
    n_cmp++; if ({d_rvalid, d_fault} !== 2'b00) begin n_err++;
      $display("FAIL flt_pulse: got v=%b f=%b expected 0 0", d_rvalid, d_fault); end
    ram_flt = 0;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    tick(); tick(); tick();
    n_cmp++; if ({d_rvalid, d_fault, d_rdata} !== {1'b1, 1'b0, 32'hC0DE0020}) begin n_err++;
      $display("FAIL flt_next: got v=%b f=%b d=%h expected 1 0 c0de0020", d_rvalid, d_fault, d_rdata); end
    d_req = 0;
    tick();
    $display("txn d write with RAM fault, then d read rdata=%h", d_rdata);
  endtask

  task automatic test_aging();
    int g [32];
    int n = 0;
    int nx = 0;
    ram_auto = 1; ram_use_addr = 1; ram_flt = 0;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    x_req = 1; x_we = 0; x_addr = 32'h300;
    for (int c = 0; c < 300 && n < 32; c++) begin
      tick();
      if (m_req) begin g[n] = int'(m_addr[11:8]); n++; end
    end
    d_req = 0; x_req = 0;
    for (int k = 0; k < 6; k++) tick();
    n_cmp++; if (n !== 32) begin n_err++;
      $display("FAIL age_count: grants got %0d expected 32", n); end
    for (int k = 0; k < n; k++) if (g[k] == 3) nx++;
`ifdef HARVOS_SCHED_AGING_EN
    if (n == 32) begin
      n_cmp++; if ({g[14], g[15], g[16], g[31]} !== {32'd1, 32'd3, 32'd1, 32'd3}) begin n_err++;
        $display("FAIL age_slots: got %0d %0d %0d %0d expected 1 3 1 3", g[14], g[15], g[16], g[31]); end
    end
    n_cmp++; if (nx !== 2) begin n_err++;
      $display("FAIL age_x_grants: got %0d expected 2", nx); end
`else
    n_cmp++; if (nx !== 0) begin n_err++;
      $display("FAIL prio_x_grants: got %0d expected 0", nx); end
`endif
    $display("txn d+x continuous: %0d grants, %0d to x", n, nx);
  endtask

  initial begin
    m_rvalid = 0; m_rdata = 0; m_fault = 0;
    test_reset();
    test_read();
    test_three();
    test_timeout();
    test_reset_mid();
    test_fault();
    test_aging();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
